cache_fill_fsm: RTL and testbench
=================================

# cache_fill_fsm

Miss-handling controller that sits between the CPU's instruction/data cache lookup and the multi-cycle main memory. On a cache miss it fetches the full 16-byte block (eight 16-bit words) with pipelined reads. It steers each returned word into the cache data array, then writes the tag. While a fill is in progress it holds the pipeline stall line (`fsm_busy`).

## Interface
Parameters:
- `WORDS`, 8, words per cache block; fixed by the 16-byte block, 2-byte word format.
- `MEM_LATENCY`, 4, nominal main-memory read latency in cycles; used only by the bench. The RTL counts returned valid words instead.

Ports:
- `clk`  in  1  system clock, single domain.
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`.
- `miss_detected`  in  1  cache lookup missed this cycle.
- `miss_address`  in  16  byte address of the missing access.
- `memory_data`  in  16  read data from main memory.
- `memory_data_valid`  in  1  `memory_data` holds a returned word this cycle.
- `fsm_busy`  out  1  fill in progress; the CPU stalls IF/MEM on it.
- `mem_read_req`  out  1  issue a read of `memory_address` this cycle.
- `memory_address`  out  16  read address sent to main memory.
- `write_data_array`  out  1  write `memory_data` into the data array this cycle.
- `data_array_addr`  out  16  byte address of the word being written into the data array.
- `write_tag_array`  out  1  write the tag and set the valid bit for the block.
- `fill_done`  out  1  single-cycle pulse: block complete.

## Operation
- Two states: IDLE and FILL. The state register, `base[15:4]`, `req_cnt[3:0]` and `rcv_cnt[3:0]` are all clocked registers.
- IDLE:
  - All outputs are 0 and `memory_address` is 16'h0000.
  - If `miss_detected` is high, latch `base` = `miss_address[15:4]`, clear both counters, and go to FILL.
- FILL, request side:
  - While `req_cnt` < 8, drive `mem_read_req` = 1 and `memory_address` = {`base`, `req_cnt[2:0]`, 1'b0}, then increment `req_cnt`.
  - Once `req_cnt` = 8, `mem_read_req` = 0 and `memory_address` = 16'h0000.
- FILL, receive side:
  - `write_data_array` = `memory_data_valid`.
  - `data_array_addr` = {`base`, `rcv_cnt[2:0]`, 1'b0}.
  - `rcv_cnt` increments on each valid.
  - Words are written in request order. Memory returns them in order; the block does no reordering.
- Completion:
  - Completion is the cycle in FILL where `memory_data_valid` = 1 and `rcv_cnt` = 7.
  - In that cycle `write_tag_array` = 1 and `fill_done` = 1, combinationally, alongside the eighth `write_data_array`.
  - The next state is IDLE.
- `fsm_busy` = 1 exactly while the state is FILL.
- `data_array_addr` is 16'h0000 in IDLE.

## Timing
- Reset:
  - `rst_n` = 0 at a rising edge forces IDLE, `base` = 0 and both counters = 0.
  - Every output is therefore 0 in the following cycle.
  - Reset mid-fill abandons the block without writing the tag. Late memory valids arriving in IDLE are ignored.
- Nominal fill, with `miss_detected` sampled at edge 0:
  - Cycles 1–8: `fsm_busy` = 1; `mem_read_req` is high in each cycle with addresses base+0, +2, …, +14.
  - Cycles 5–12: data returns, assuming 4-cycle latency.
  - Cycle 12: `write_tag_array` and `fill_done` pulse.
  - Cycle 13: IDLE, `fsm_busy` = 0.
  - Total `fsm_busy` duration is 12 cycles.
- Latency tolerance:
  - Completion depends only on counting 8 valids, so longer or variable latency and gaps between valids just stretch FILL.
  - `req_cnt` saturates at 8; no 9th request is ever issued.
- `miss_detected` while in FILL, including the completion cycle, is ignored. A new miss is accepted no earlier than the first IDLE cycle.
- `miss_address` changing during FILL has no effect, because `base` is latched.
- `memory_data_valid` in IDLE produces no write and no state change.
- Block offset bits `miss_address[3:0]` are discarded; the fill always starts at word 0.
- Wrap: `base` = 12'hFFF fills 16'hFFF0–16'hFFFE. There is no carry out of `base`.

## Test plan
- Reset, then `miss_detected` = 1 with `miss_address` = 16'h1236, memory latency 4 → requests 16'h1230, 1232, …, 123E on cycles 1–8; `write_data_array` on cycles 5–12 with `data_array_addr` stepping 16'h1230→123E; `write_tag_array`/`fill_done` pulse only on cycle 12; `fsm_busy` high for cycles 1–12.
- Valids with latency 4 plus a 3-cycle gap after the 3rd word → exactly 8 requests; completion on cycle 15; data-array addresses still in order.
- Re-assert `miss_detected` on cycle 6 with address 16'hABCD → ignored, all addresses stay 16'h123x; on completion-cycle assertion also ignored; a new miss at cycle 13 starts a fill of 16'hABC0.
- `rst_n` low during cycle 7 of a fill → next cycle all outputs 0 and no tag write; a subsequent valid pulse in IDLE writes nothing; a fresh miss fills correctly.
- `miss_address` = 16'hFFFF → requests 16'hFFF0–16'hFFFE, no address wraps to 16'h0000.
- Back-to-back misses (second `miss_detected` held from cycle 12 to 13) → second fill's `fsm_busy` on cycles 14–25, no overlap or dropped word.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling controller that fills one 16-byte cache
// block (eight 16-bit words) from main memory using pipelined reads.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   miss_detected       - cache lookup missed this cycle
//   miss_address[15:0]  - byte address of the missing access
//   memory_data[15:0]   - read data from main memory (routed externally)
//   memory_data_valid   - memory_data holds a returned word this cycle
//   fsm_busy            - fill in progress, pipeline stall
//   mem_read_req        - issue a read of memory_address this cycle
//   memory_address      - read address sent to main memory
//   write_data_array    - write the returned word into the data array
//   data_array_addr     - byte address of the word being written
//   write_tag_array     - write tag and set valid for the block
//   fill_done           - single-cycle block-complete pulse
module cache_fill_fsm #(
    parameter int WORDS       = 8,
    parameter int MEM_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic [15:0] memory_data,
    input  logic        memory_data_valid,
    output logic        fsm_busy,
    output logic        mem_read_req,
    output logic [15:0] memory_address,
    output logic        write_data_array,
    output logic [15:0] data_array_addr,
    output logic        write_tag_array,
    output logic        fill_done
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam logic [3:0] REQ_LIMIT = 4'(WORDS);
    localparam logic [3:0] RCV_LAST  = 4'(WORDS - 1);

    state_e      state_q, state_d;
    logic [11:0] base_q,  base_d;
    logic [3:0]  req_cnt_q, req_cnt_d;
    logic [3:0]  rcv_cnt_q, rcv_cnt_d;

    // Data itself goes straight from memory to the data array; the block
    // offset is dropped because a fill always starts at word 0.
    logic unused_ok;
    assign unused_ok = ^{memory_data, miss_address[3:0], 1'(MEM_LATENCY)};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            req_cnt_q <= '0;
            rcv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        base_d           = base_q;
        req_cnt_d        = req_cnt_q;
        rcv_cnt_d        = rcv_cnt_q;
        fsm_busy         = 1'b0;
        mem_read_req     = 1'b0;
        memory_address   = 16'h0000;
        write_data_array = 1'b0;
        data_array_addr  = 16'h0000;
        write_tag_array  = 1'b0;
        fill_done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    base_d    = miss_address[15:4];
                    req_cnt_d = '0;
                    rcv_cnt_d = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;

                // Request side saturates after the last word is issued.
                if (req_cnt_q < REQ_LIMIT) begin
                    mem_read_req   = 1'b1;
                    memory_address = {base_q, req_cnt_q[2:0], 1'b0};
                    req_cnt_d      = req_cnt_q + 4'd1;
                end

                // Memory returns words in request order, so the receive
                // count alone selects the destination word.
                write_data_array = memory_data_valid;
                data_array_addr  = {base_q, rcv_cnt_q[2:0], 1'b0};

                if (memory_data_valid) begin
                    rcv_cnt_d = rcv_cnt_q + 4'd1;
                    if (rcv_cnt_q == RCV_LAST) begin
                        write_tag_array = 1'b1;
                        fill_done       = 1'b1;
                        state_d         = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: directed self-checking bench for cache_fill_fsm.
// Drives misses and memory valids cycle by cycle and checks all outputs.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] memory_data;
    logic        memory_data_valid;
    logic        fsm_busy;
    logic        mem_read_req;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [15:0] data_array_addr;
    logic        write_tag_array;
    logic        fill_done;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOM = 32'h0000_1FE0;  // valids on cycles 5..12
    localparam logic [31:0] GAP = 32'h0000_F8E0;  // 5,6,7 then 11..15

    cache_fill_fsm #(.WORDS(8), .MEM_LATENCY(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data       (memory_data),
        .memory_data_valid (memory_data_valid),
        .fsm_busy          (fsm_busy),
        .mem_read_req      (mem_read_req),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .data_array_addr   (data_array_addr),
        .write_tag_array   (write_tag_array),
        .fill_done         (fill_done)
    );

    always #5 clk = ~clk;

    function automatic logic [36:0] pack(
        input logic        busy,
        input logic        req,
        input logic [15:0] ma,
        input logic        wda,
        input logic [15:0] da,
        input logic        tag,
        input logic        done
    );
        return {busy, req, ma, wda, da, tag, done};
    endfunction

    task automatic check(input string tag, input logic [36:0] exp);
        logic [36:0] obs;
        obs = {fsm_busy, mem_read_req, memory_address, write_data_array,
               data_array_addr, write_tag_array, fill_done};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input string tag, input logic v);
        miss_detected     = 1'b0;
        memory_data_valid = v;
        memory_data       = 16'hBEEF;
        #1;
        check(tag, '0);
        next_cycle();
        memory_data_valid = 1'b0;
    endtask

    // Cycle 0 asserts the miss in IDLE; cycle c (c>=1) is the c-th FILL
    // cycle. Requests are expected on cycles 1..8 at block+2*(c-1); the
    // k-th returned word lands at block+2*(k-1); the eighth word completes.
    task automatic do_fill(
        input string       tag,
        input logic [15:0] addr,
        input logic [31:0] vmask,
        input logic [31:0] mmask,
        input logic [15:0] addr2,
        input int          exp_end,
        input int          abort_c
    );
        logic [15:0] blk;
        logic [15:0] ma;
        logic        req;
        logic        last;
        int          k;
        bit          ended;
        blk   = {addr[15:4], 4'h0};
        k     = 0;
        ended = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = addr;
        memory_data_valid = 1'b0;
        #1;
        check($sformatf("%s:c0", tag), '0);
        next_cycle();
        for (int c = 1; c < 32; c++) begin
            memory_data_valid = vmask[c];
            miss_detected     = mmask[c];
            miss_address      = mmask[c] ? addr2 : addr;
            memory_data       = 16'hD000 ^ 16'(c);
            if (c == abort_c) rst_n = 1'b0;
            #1;
            req  = (c <= 8);
            ma   = req ? blk + 16'(2 * (c - 1)) : 16'h0000;
            last = vmask[c] && (k == 7);
            check($sformatf("%s:c%0d", tag, c),
                  pack(1'b1, req, ma, vmask[c], blk + 16'(2 * k), last, last));
            if (vmask[c]) k++;
            next_cycle();
            if (c == abort_c) begin
                rst_n = 1'b1;
                ended = 1'b1;
                break;
            end
            if (last) begin
                check_int($sformatf("%s:end", tag), c, exp_end);
                ended = 1'b1;
                break;
            end
        end
        if (!ended) begin
            total++;
            bad++;
            $error("FAIL %s:timeout obs=no_done exp=done", tag);
        end
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        miss_detected     = 1'b1;
        miss_address      = 16'h4444;
        memory_data       = 16'h0000;
        memory_data_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", '0);
        rst_n = 1'b1;
        idle_check("idle0", 1'b0);
        idle_check("idle_valid", 1'b1);
        idle_check("idle_after", 1'b0);

        do_fill("nom", 16'h1236, NOM, 32'h0, 16'h0, 12, 0);
        idle_check("nom_post", 1'b0);

        do_fill("gap", 16'h1236, GAP, 32'h0, 16'h0, 15, 0);
        idle_check("gap_post", 1'b0);

        do_fill("ign", 16'h1236, NOM, 32'h0000_1040, 16'hABCD, 12, 0);
        do_fill("ign2", 16'hABCD, NOM, 32'h0, 16'h0, 12, 0);
        idle_check("ign_post", 1'b0);

        do_fill("rst", 16'h5552, NOM, 32'h0, 16'h0, 0, 7);
        idle_check("rst_c8", 1'b1);
        idle_check("rst_c9", 1'b1);
        do_fill("rst2", 16'h7770, NOM, 32'h0, 16'h0, 12, 0);
        idle_check("rst2_post", 1'b0);

        do_fill("wrap", 16'hFFFF, NOM, 32'h0, 16'h0, 12, 0);
        idle_check("wrap_post", 1'b0);

        do_fill("b2b1", 16'h2468, NOM, 32'h0000_1000, 16'h1357, 12, 0);
        do_fill("b2b2", 16'h1357, NOM, 32'h0, 16'h0, 12, 0);
        idle_check("b2b_post", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
